// File: rtl/seg7_pkg.sv
// Purpose: shared BCD digit type and seven-segment encoding for the counter display.
// Latency: combinational helper only.
// Backpressure: none; pure function of its input.
package seg7_pkg;

    typedef logic [3:0] bcd_t;
    typedef logic [6:0] seg_t;

    // Active-low segment patterns, bit0=a .. bit6=g
    localparam seg_t SEG_BLANK = 7'b1111111;
    localparam seg_t SEG_ZERO  = 7'b1000000;

    // Non-decimal codes render blank so a corrupt digit is visible as a dark display
    function automatic seg_t seg7_encode(input bcd_t d);
        seg_t s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0011000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Purpose: synchronise and debounce one active-low push button, emit a press pulse.
// Latency: press pulse 2+DEBOUNCE_CYCLES cycles after a stable low level reaches key_n.
// Backpressure: none; the pulse is one cycle wide and is not held for a consumer.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic CLOCK_50,
    input  logic RESET,
    input  logic key_n,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // Two-flop synchroniser; resets to the released level so a held key is seen as a fresh press
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
        end
    end

    // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples; any agreeing sample restarts the count
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            cnt   <= '0;
            level <= 1'b1;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            if (sync2 != level) begin
                if (cnt == CNT_LAST) begin
                    cnt   <= '0;
                    level <= sync2;
                    press <= ~sync2;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/bcd_counter_display.sv
// Purpose: N-digit BCD up/down counter with key entry, auto tick, and seven-segment output.
// Latency: count updates the cycle after a step/entry pulse; HEX follows count one cycle later.
// Backpressure: none; every event pulse is consumed in the cycle it occurs or discarded.
module bcd_counter_display
    import seg7_pkg::*;
#(
    parameter int DIGITS          = 4,
    parameter int TICK_DIV        = 50_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic                CLOCK_50,
    input  logic                RESET,
    input  logic [1:0]          KEY,
    input  logic [9:0]          SW,
    output logic [7*DIGITS-1:0] HEX,
    output logic [1:0]          LEDR
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic                   step_press;
    logic                   entry_press;
    logic                   step_level;
    logic                   entry_level;
    logic [PW-1:0]          presc;
    logic                   tick;
    logic                   step_pulse;
    bcd_t [DIGITS-1:0]      count;
    bcd_t [DIGITS-1:0]      stepped;
    bcd_t [DIGITS-1:0]      entered;
    logic                   step_wrap;
    logic                   wrap;
    logic                   auto_q;
    logic                   entry_ok;
    logic [7*DIGITS-1:0]    hex_next;
    logic                   unused_inputs;

    assign unused_inputs = ^{SW[6:4], step_level, entry_level};

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_step (
        .CLOCK_50 (CLOCK_50),
        .RESET    (RESET),
        .key_n    (KEY[0]),
        .level    (step_level),
        .press    (step_press)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_entry (
        .CLOCK_50 (CLOCK_50),
        .RESET    (RESET),
        .key_n    (KEY[1]),
        .level    (entry_level),
        .press    (entry_press)
    );

    // Auto-mode prescaler; parked at zero in manual mode so each auto run starts a full period
    always_ff @(posedge CLOCK_50) begin
        if (RESET || !SW[9]) begin
            presc <= '0;
        end else if (presc == PRESC_LAST) begin
            presc <= '0;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    assign tick       = SW[9] && (presc == PRESC_LAST);
    assign step_pulse = SW[9] ? tick : step_press;
    assign entry_ok   = (SW[3:0] <= 4'd9);

    // Ripple the +1/-1 through the digits; a carry/borrow left over means the whole counter wrapped
    always_comb begin
        logic carry;
        stepped = count;
        carry   = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (!SW[8]) begin
                    if (count[i] == 4'd9) begin
                        stepped[i] = 4'd0;
                    end else begin
                        stepped[i] = count[i] + 4'd1;
                        carry      = 1'b0;
                    end
                end else begin
                    if (count[i] == 4'd0) begin
                        stepped[i] = 4'd9;
                    end else begin
                        stepped[i] = count[i] - 4'd1;
                        carry      = 1'b0;
                    end
                end
            end
        end
        step_wrap = carry;
    end

    // Calculator-style entry: existing digits move up one place, the switch digit enters at the bottom
    always_comb begin
        entered = count;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            entered[i] = count[i-1];
        end
        entered[0] = SW[3:0];
    end

    // Count and wrap state; an entry press always consumes the cycle, so a coincident step is dropped
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            count <= '0;
            wrap  <= 1'b0;
        end else if (entry_press) begin
            if (entry_ok) begin
                count <= entered;
                wrap  <= 1'b0;
            end
        end else if (step_pulse) begin
            count <= stepped;
            if (step_wrap) begin
                wrap <= 1'b1;
            end
        end
    end

    // Decode digits, blanking zeros above the most significant nonzero digit; digit 0 always shows
    always_comb begin
        logic leading;
        hex_next = '0;
        leading  = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (count[i] != 4'd0) begin
                leading = 1'b0;
            end
            if (SW[7] && leading && (i != 0)) begin
                hex_next[7*i +: 7] = SEG_BLANK;
            end else begin
                hex_next[7*i +: 7] = seg7_encode(count[i]);
            end
        end
    end

    // Registered display and mode indicator
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            HEX    <= {DIGITS{SEG_ZERO}};
            auto_q <= 1'b0;
        end else begin
            HEX    <= hex_next;
            auto_q <= SW[9];
        end
    end

    assign LEDR = {auto_q, wrap};

endmodule

// File: tb/tb_bcd_counter_display.sv
// Purpose: self-checking bench for bcd_counter_display against an integer reference model.
// Latency: key actions are held long enough for synchroniser plus debounce, then settled.
// Backpressure: not applicable.
module tb_bcd_counter_display;

    localparam int DIGITS = 4;
    localparam int MODV   = 10000;

    logic                clk = 1'b0;
    logic                rst;
    logic [1:0]          key;
    logic [9:0]          sw;
    logic [7*DIGITS-1:0] hex;
    logic [1:0]          ledr;

    int checks   = 0;
    int failures = 0;

    // Reference model state: counter value as a plain integer plus the wrap flag
    int m_count;
    bit m_wrap;

    logic [6:0] seg_tab [10];

    bcd_counter_display #(
        .DIGITS          (DIGITS),
        .TICK_DIV        (8),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .CLOCK_50 (clk),
        .RESET    (rst),
        .KEY      (key),
        .SW       (sw),
        .HEX      (hex),
        .LEDR     (ledr)
    );

    always #5 clk = ~clk;

    task automatic tk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected display for a decimal value, derived digit by digit with division
    function automatic logic [31:0] exp_hex(input int c, input bit blank);
        logic [31:0] h;
        int d [DIGITS];
        int msnz;
        h    = '0;
        msnz = 0;
        for (int i = 0; i < DIGITS; i++) begin
            d[i] = (c / (10 ** i)) % 10;
            if (d[i] != 0) msnz = i;
        end
        for (int i = 0; i < DIGITS; i++) begin
            if (blank && i > msnz) h[7*i +: 7] = 7'b1111111;
            else                   h[7*i +: 7] = seg_tab[d[i]];
        end
        return h;
    endfunction

    task automatic press_key(input int k);
        key[k] = 1'b0;
        tk(8);
        key[k] = 1'b1;
        tk(8);
    endtask

    task automatic model_step(input bit down);
        if (!down) begin
            if (m_count == MODV - 1) begin m_count = 0; m_wrap = 1'b1; end
            else m_count = m_count + 1;
        end else begin
            if (m_count == 0) begin m_count = MODV - 1; m_wrap = 1'b1; end
            else m_count = m_count - 1;
        end
    endtask

    task automatic model_entry(input int d);
        if (d <= 9) begin
            m_count = (m_count * 10 + d) % MODV;
            m_wrap  = 1'b0;
        end
    endtask

    task automatic enter(input int d);
        sw[3:0] = 4'(d);
        press_key(1);
        model_entry(d);
    endtask

    task automatic step(input bit down);
        sw[8] = down;
        press_key(0);
        model_step(down);
    endtask

    task automatic check_model(input string tag);
        check({tag, "_hex"}, 32'(hex), exp_hex(m_count, sw[7]));
        check({tag, "_wrap"}, 32'(ledr[0]), 32'(m_wrap));
    endtask

    initial begin
        logic [7:0] bounce;
        seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
        seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
        seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
        seg_tab[9] = 7'b0011000;
        m_count = 0;
        m_wrap  = 1'b0;
        rst = 1'b1;
        key = 2'b11;
        sw  = '0;

        // Reset state and idle display
        tk(3);
        check("reset_hex", 32'(hex), exp_hex(0, 1'b0));
        check("reset_ledr", 32'(ledr), 32'd0);
        rst = 1'b0;
        tk(10);
        check("idle_hex", 32'(hex), exp_hex(0, 1'b0));
        check("idle_ledr", 32'(ledr), 32'd0);
        sw[7] = 1'b1;
        tk(2);
        check("idle_blank", 32'(hex), {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000});
        sw[7] = 1'b0;
        tk(2);

        // Bouncing KEY0 yields a single step; release yields none
        bounce = 8'b0000_0101;
        for (int i = 0; i < 8; i++) begin
            key[0] = bounce[i];
            tk(1);
        end
        tk(12);
        model_step(1'b0);
        check("bounce_hex", 32'(hex), exp_hex(m_count, 1'b0));
        check("bounce_hex0", 32'(hex[6:0]), 32'(7'b1111001));
        key[0] = 1'b1;
        tk(12);
        check("release_hex", 32'(hex), exp_hex(m_count, 1'b0));

        // Entry to 9999 then up-wrap, then entry clears wrap
        for (int i = 0; i < 4; i++) enter(9);
        check("entry9999_hex", 32'(hex), exp_hex(9999, 1'b0));
        step(1'b0);
        check("upwrap_hex", 32'(hex), exp_hex(0, 1'b0));
        check("upwrap_ledr", 32'(ledr), 32'd1);
        enter(3);
        check("entry3_hex", 32'(hex), exp_hex(3, 1'b0));
        check("entry3_ledr", 32'(ledr), 32'd0);

        // Down-wrap from zero, then an out-of-range entry is ignored
        rst = 1'b1;
        tk(1);
        rst = 1'b0;
        m_count = 0;
        m_wrap  = 1'b0;
        tk(2);
        step(1'b1);
        check("downwrap_hex", 32'(hex), exp_hex(9999, 1'b0));
        check("downwrap_ledr", 32'(ledr), 32'd1);
        enter(12);
        check("badentry", 32'(hex), exp_hex(9999, 1'b0));
        check("badentry_ledr", 32'(ledr), 32'd1);
        sw[8] = 1'b0;

        // Auto mode: one up-step every 8 cycles starting from 0005
        for (int i = 0; i < 4; i++) enter(i == 3 ? 5 : 0);
        check("auto_start", 32'(hex), exp_hex(5, 1'b0));
        sw[9] = 1'b1;
        for (int k = 1; k <= 41; k++) begin
            tk(1);
            check($sformatf("auto_k%0d", k), 32'(hex), exp_hex(5 + (k - 1) / 8, 1'b0));
        end
        check("auto_led", 32'(ledr[1]), 32'd1);
        m_count = 10;
        tk(3);
        sw[9] = 1'b0;
        tk(20);
        check("auto_stop", 32'(hex), exp_hex(10, 1'b0));
        check("auto_stop_led", 32'(ledr[1]), 32'd0);

        // Coincident entry and step: entry wins
        for (int i = 0; i < 4; i++) enter(i < 2 ? 0 : i - 1);
        check("pre_coincide", 32'(hex), exp_hex(12, 1'b0));
        sw[3:0] = 4'd4;
        key = 2'b00;
        tk(8);
        key = 2'b11;
        tk(8);
        model_entry(4);
        check("coincide", 32'(hex), exp_hex(124, 1'b0));

        // Reset mid-debounce with KEY0 held through it
        key[0] = 1'b0;
        tk(2);
        rst = 1'b1;
        tk(1);
        check("midreset_hex", 32'(hex), exp_hex(0, 1'b0));
        rst = 1'b0;
        m_count = 0;
        m_wrap  = 1'b0;
        tk(7);
        check("held_pre", 32'(hex), exp_hex(0, 1'b0));
        tk(1);
        check("held_press", 32'(hex), exp_hex(1, 1'b0));
        tk(20);
        check("held_once", 32'(hex), exp_hex(1, 1'b0));
        key[0] = 1'b1;
        tk(10);
        m_count = 1;

        // Randomised entries and manual steps against the model
        for (int n = 0; n < 30; n++) begin
            sw[7] = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 2))
                0:       enter(int'($urandom_range(0, 15)));
                1:       step(1'b0);
                default: step(1'b1);
            endcase
            check_model($sformatf("rand%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
